niosduino_gpio: RTL and testbench
=================================

# niosduino_gpio

Parametrised Avalon-MM bidirectional GPIO peripheral: the successor to the NIOSDuino core's fixed 8- and 32-bit PIO exports. Adds per-bit direction control, atomic set/clear of output bits, a synchronised input path, per-bit rising/falling edge capture, and a maskable level interrupt to the Nios II. Sits on the core's Avalon-MM data bus, with `pio_export` routed to the Arduino-style header pins.

## Interface
- `WIDTH`, 32: number of GPIO bits, 1..32.
- `SYNC_STAGES`, 2: input synchroniser depth, 2..4.
- `RESET_DIR`, 0: reset value of DIR. Bit=1 means output.
- `RESET_OUT`, 0: reset value of the output register.

Ports:
- `clk_in_clk` in 1: single clock. All logic is on its rising edge.
- `reset_reset_n` in 1: asynchronous, active-low reset.
- `avs_address` in 3: word address.
- `avs_read` in 1: read strobe.
- `avs_write` in 1: write strobe.
- `avs_writedata` in 32: write data.
- `avs_byteenable` in 4: write byte lanes.
- `avs_readdata` out 32: read data, fixed latency 1.
- `irq` out 1: level interrupt, registered.
- `pio_export` inout WIDTH: pins. Bit i is driven with `out[i]` when `dir[i]`=1, otherwise Z.

## Operation
- Register map (word address):
  - 0 DATA: read returns synchronised pin value; write loads the output register.
  - 1 DIR: read/write.
  - 2 IRQ_MASK: read/write.
  - 3 EDGE_CAP: read returns captured bits; write-1-to-clear.
  - 4 OUT_SET: write-1 sets output bits; reads 0.
  - 5 OUT_CLR: write-1 clears output bits; reads 0.
  - 6 RISE_EN: read/write.
  - 7 FALL_EN: read/write.
- Byte lanes:
  - On plain registers, disabled byte lanes keep their old value.
  - On OUT_SET, OUT_CLR and EDGE_CAP, disabled lanes count as zero.
- Bits at or above WIDTH read 0; writes to them are ignored.
- Input path:
  - Pins pass through a SYNC_STAGES flop chain to give `sync`.
  - A further `prev` register holds the previous value of `sync`.
  - Rising edge on bit i: `sync[i] & ~prev[i] & rise_en[i]`. Falling edge: `~sync[i] & prev[i] & fall_en[i]`.
  - A detected edge sets `edge_cap[i]`.
  - Detection applies regardless of direction, so output bits loop back through the pin.
- Interrupt: `irq` is registered from `|(edge_cap & irq_mask)`.
- Simultaneous events:
  - A new edge and a W1C on the same bit in the same cycle: the bit stays set.
  - `avs_read` and `avs_write` both asserted: the write is performed, the read is ignored, and readdata returns 0 on the next cycle.

## Timing
- Reset values:
  - DIR=RESET_DIR, out=RESET_OUT.
  - IRQ_MASK, EDGE_CAP, RISE_EN, FALL_EN, `sync` chain, `prev`, `avs_readdata` and `irq` are all 0.
- Writes:
  - A register write takes effect at the clock edge of the strobe cycle.
  - The pin drive changes in the cycle following the strobe.
  - No wait states.
- Reads: `avs_readdata` is valid exactly 1 cycle after the `avs_read` cycle. It is 0 in every cycle not following a read.
- Input latency:
  - A pin change appears in DATA reads SYNC_STAGES cycles later.
  - The edge sets EDGE_CAP at SYNC_STAGES+1.
  - `irq` rises at SYNC_STAGES+2.
- Clearing: after a W1C of the last pending masked bit, `irq` deasserts 2 cycles after the write strobe.
- Reset mid-operation: reset is asynchronous. All state returns to reset values immediately, and in-flight reads return 0.

## Structure
- Shared package `niosduino_gpio_pkg`:
  - Register address constants: ADDR_DATA .. ADDR_FALL_EN.
  - Byte-enable expansion function, 4 bits to a 32-bit mask.
- One sub-module, `niosduino_sync`: a WIDTH×SYNC_STAGES synchroniser with asynchronous active-low reset to 0. Reusable for the UART and flash inputs.
- The top level holds the register file, edge logic, tristate and readdata mux.

## Test plan
- Reset with RESET_DIR=0, RESET_OUT=0: all pins are Z; every address 0..7 reads 0; `irq`=0.
- Write DIR=0xFF, DATA=0xA5, OUT_SET=0x0A, OUT_CLR=0x81 (byteenable=0xF):
  - pins[7:0] end at 0x2E.
  - DATA reads 0x2E after SYNC_STAGES+1 cycles.
- Write DATA=0xFFFFFFFF with byteenable=0x2 on WIDTH=32: out becomes 0x0000FF00.
- RISE_EN=0x1, IRQ_MASK=0x1, drive pin0 0→1:
  - EDGE_CAP=0x1 at SYNC_STAGES+1.
  - `irq`=1 at SYNC_STAGES+2.
  - W1C 0x1 → `irq`=0 two cycles later.
  - A falling edge on pin0 with FALL_EN=0 leaves EDGE_CAP at 0.
- Edge on pin3 (RISE_EN bit3=1) arriving in the same cycle as a W1C write of 0x8: EDGE_CAP bit3 remains 1.
- With WIDTH=8, write 0xFFFFFFFF to DIR: DIR reads 0x000000FF, and read latency is 1 cycle.

Source files
------------

// File: rtl/niosduino_gpio_pkg.sv
// Shared definitions for the niosduino_gpio peripheral: register word addresses
// and the Avalon byte-enable to bit-mask expansion.
package niosduino_gpio_pkg;

  localparam logic [2:0] ADDR_DATA     = 3'd0;
  localparam logic [2:0] ADDR_DIR      = 3'd1;
  localparam logic [2:0] ADDR_IRQ_MASK = 3'd2;
  localparam logic [2:0] ADDR_EDGE_CAP = 3'd3;
  localparam logic [2:0] ADDR_OUT_SET  = 3'd4;
  localparam logic [2:0] ADDR_OUT_CLR  = 3'd5;
  localparam logic [2:0] ADDR_RISE_EN  = 3'd6;
  localparam logic [2:0] ADDR_FALL_EN  = 3'd7;

  function automatic logic [31:0] be_to_mask(input logic [3:0] be);
    return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
  endfunction

endpackage

// File: rtl/niosduino_gpio_if.sv
// Avalon-MM slave bus bundle for the GPIO peripheral (fixed read latency 1).
interface niosduino_gpio_if;

  logic [2:0]  avs_address;
  logic        avs_read;
  logic        avs_write;
  logic [31:0] avs_writedata;
  logic [3:0]  avs_byteenable;
  logic [31:0] avs_readdata;

  modport master (
    output avs_address, avs_read, avs_write, avs_writedata, avs_byteenable,
    input  avs_readdata
  );

  modport slave (
    input  avs_address, avs_read, avs_write, avs_writedata, avs_byteenable,
    output avs_readdata
  );

endinterface

// File: rtl/niosduino_sync.sv
// WIDTH x STAGES flop-chain synchroniser, async active-low reset to 0.
// Shared with the UART and flash input paths.
module niosduino_sync #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [STAGES-1:0][WIDTH-1:0] chain;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) chain <= '0;
    else        chain <= {chain[STAGES-2:0], d};
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/niosduino_gpio.sv
// Avalon-MM bidirectional GPIO: register file, atomic set/clear, synchronised
// input with edge capture, maskable registered interrupt and pin tristate.
module niosduino_gpio
  import niosduino_gpio_pkg::*;
#(
  parameter int          WIDTH       = 32,
  parameter int          SYNC_STAGES = 2,
  parameter logic [31:0] RESET_DIR   = '0,
  parameter logic [31:0] RESET_OUT   = '0
) (
  input  logic                 clk_in_clk,
  input  logic                 reset_reset_n,
  niosduino_gpio_if.slave      avs,
  output logic                 irq,
  inout  wire  [WIDTH-1:0]     pio_export
);

  logic [WIDTH-1:0] dir;
  logic [WIDTH-1:0] out_reg;
  logic [WIDTH-1:0] irq_mask;
  logic [WIDTH-1:0] edge_cap;
  logic [WIDTH-1:0] rise_en;
  logic [WIDTH-1:0] fall_en;
  logic [WIDTH-1:0] sync_q;
  logic [WIDTH-1:0] prev_q;
  logic [WIDTH-1:0] edge_new;
  logic [31:0]      be_mask;
  logic [WIDTH-1:0] lane_mask;
  logic [WIDTH-1:0] wdata;
  logic [WIDTH-1:0] wbits;
  logic [31:0]      rd_word;

  niosduino_sync #(.WIDTH(WIDTH), .STAGES(SYNC_STAGES)) u_sync (
    .clk   (clk_in_clk),
    .rst_n (reset_reset_n),
    .d     (pio_export),
    .q     (sync_q)
  );

  for (genvar i = 0; i < WIDTH; i++) begin : g_pin
    assign pio_export[i] = dir[i] ? out_reg[i] : 1'bz;
  end

  assign be_mask   = be_to_mask(avs.avs_byteenable);
  assign lane_mask = be_mask[WIDTH-1:0];
  assign wdata     = avs.avs_writedata[WIDTH-1:0];
  // Set/clear/W1C registers treat disabled lanes as zero bits.
  assign wbits     = wdata & lane_mask;
  assign edge_new  = (sync_q & ~prev_q & rise_en) | (~sync_q & prev_q & fall_en);

  function automatic logic [WIDTH-1:0] merge(input logic [WIDTH-1:0] old);
    return (old & ~lane_mask) | (wdata & lane_mask);
  endfunction

  always_comb begin
    rd_word = '0;
    case (avs.avs_address)
      ADDR_DATA:     rd_word[WIDTH-1:0] = sync_q;
      ADDR_DIR:      rd_word[WIDTH-1:0] = dir;
      ADDR_IRQ_MASK: rd_word[WIDTH-1:0] = irq_mask;
      ADDR_EDGE_CAP: rd_word[WIDTH-1:0] = edge_cap;
      ADDR_RISE_EN:  rd_word[WIDTH-1:0] = rise_en;
      ADDR_FALL_EN:  rd_word[WIDTH-1:0] = fall_en;
      default:       rd_word = '0;
    endcase
  end

  always_ff @(posedge clk_in_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      dir              <= RESET_DIR[WIDTH-1:0];
      out_reg          <= RESET_OUT[WIDTH-1:0];
      irq_mask         <= '0;
      edge_cap         <= '0;
      rise_en          <= '0;
      fall_en          <= '0;
      prev_q           <= '0;
      irq              <= 1'b0;
      avs.avs_readdata <= '0;
    end else begin
      prev_q <= sync_q;
      irq    <= |(edge_cap & irq_mask);

      // A fresh edge wins over a same-cycle W1C of that bit.
      if (avs.avs_write && avs.avs_address == ADDR_EDGE_CAP)
        edge_cap <= (edge_cap & ~wbits) | edge_new;
      else
        edge_cap <= edge_cap | edge_new;

      if (avs.avs_write) begin
        case (avs.avs_address)
          ADDR_DATA:     out_reg  <= merge(out_reg);
          ADDR_DIR:      dir      <= merge(dir);
          ADDR_IRQ_MASK: irq_mask <= merge(irq_mask);
          ADDR_OUT_SET:  out_reg  <= out_reg | wbits;
          ADDR_OUT_CLR:  out_reg  <= out_reg & ~wbits;
          ADDR_RISE_EN:  rise_en  <= merge(rise_en);
          ADDR_FALL_EN:  fall_en  <= merge(fall_en);
          default:       ;
        endcase
      end

      avs.avs_readdata <= (avs.avs_read && !avs.avs_write) ? rd_word : '0;
    end
  end

endmodule

// File: tb/tb_niosduino_gpio.sv
// Directed bench for niosduino_gpio: register map, byte lanes, pin loopback,
// edge capture timing, interrupt, W1C collision and WIDTH=8 truncation.
module tb_niosduino_gpio;
  import niosduino_gpio_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        irq, irq8;
  logic [31:0] tb_oe, tb_val, rdata;
  wire  [31:0] pins;
  wire  [7:0]  pins8;
  int          n_chk = 0;
  int          n_fail = 0;

  niosduino_gpio_if bus ();
  niosduino_gpio_if bus8 ();

  for (genvar i = 0; i < 32; i++) begin : g_drv
    assign pins[i] = tb_oe[i] ? tb_val[i] : 1'bz;
  end

  niosduino_gpio #(.WIDTH(32), .SYNC_STAGES(2)) u_dut (
    .clk_in_clk    (clk),
    .reset_reset_n (rst_n),
    .avs           (bus.slave),
    .irq           (irq),
    .pio_export    (pins)
  );

  niosduino_gpio #(.WIDTH(8), .SYNC_STAGES(2)) u_dut8 (
    .clk_in_clk    (clk),
    .reset_reset_n (rst_n),
    .avs           (bus8.slave),
    .irq           (irq8),
    .pio_export    (pins8)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d, input logic [3:0] be);
    bus.avs_address    = a;
    bus.avs_writedata  = d;
    bus.avs_byteenable = be;
    bus.avs_write      = 1'b1;
    tick(1);
    bus.avs_write      = 1'b0;
    bus.avs_byteenable = 4'h0;
  endtask

  task automatic rd(input logic [2:0] a, output logic [31:0] d);
    bus.avs_address = a;
    bus.avs_read    = 1'b1;
    tick(1);
    bus.avs_read    = 1'b0;
    d               = bus.avs_readdata;
  endtask

  initial begin
    rst_n = 1'b0;
    tb_oe = '1;
    tb_val = '0;
    bus.avs_address = '0;  bus.avs_read = 1'b0;  bus.avs_write = 1'b0;
    bus.avs_writedata = '0; bus.avs_byteenable = '0;
    bus8.avs_address = '0; bus8.avs_read = 1'b0; bus8.avs_write = 1'b0;
    bus8.avs_writedata = '0; bus8.avs_byteenable = '0;
    #23 rst_n = 1'b1;
    tick(1);

    check("reset_irq", {31'd0, irq}, 32'd0);
    check("reset_readdata", bus.avs_readdata, 32'd0);
    for (int a = 0; a < 8; a++) begin
      rd(3'(a), rdata);
      check($sformatf("reset_rd_addr%0d", a), rdata, 32'd0);
    end

    // Output path: load, set, clear, then loop back through the synchroniser.
    tb_oe = 32'hFFFF_FF00;
    wr(ADDR_DIR, 32'h0000_00FF, 4'hF);
    wr(ADDR_DATA, 32'h0000_00A5, 4'hF);
    wr(ADDR_OUT_SET, 32'h0000_000A, 4'hF);
    wr(ADDR_OUT_CLR, 32'h0000_0081, 4'hF);
    check("pins_after_set_clr", {24'd0, pins[7:0]}, 32'h2E);
    tick(2);
    rd(ADDR_DATA, rdata);
    check("data_loopback", rdata, 32'h2E);
    tick(1);
    check("readdata_idle", bus.avs_readdata, 32'd0);
    rd(ADDR_DIR, rdata);
    check("dir_readback", rdata, 32'hFF);
    rd(ADDR_OUT_SET, rdata);
    check("out_set_reads0", rdata, 32'd0);

    // Byte lanes on plain registers keep disabled lanes.
    tb_oe = '0;
    wr(ADDR_DATA, 32'h0, 4'hF);
    wr(ADDR_DIR, 32'hFFFF_FFFF, 4'hF);
    wr(ADDR_DATA, 32'hFFFF_FFFF, 4'h2);
    check("pins_byte_lane", pins, 32'h0000_FF00);
    tick(2);
    rd(ADDR_DATA, rdata);
    check("data_byte_lane", rdata, 32'h0000_FF00);
    wr(ADDR_IRQ_MASK, 32'hFFFF_FFFF, 4'h5);
    rd(ADDR_IRQ_MASK, rdata);
    check("irq_mask_lanes", rdata, 32'h00FF_00FF);
    wr(ADDR_IRQ_MASK, 32'h0, 4'hF);
    wr(ADDR_DIR, 32'h0, 4'hF);
    tb_oe = '1;
    tb_val = '0;
    tick(4);

    // Rising edge on pin0: capture at S+1, irq at S+2, W1C clears in 2.
    wr(ADDR_RISE_EN, 32'h1, 4'hF);
    wr(ADDR_IRQ_MASK, 32'h1, 4'hF);
    tb_val[0] = 1'b1;
    tick(2);
    rd(ADDR_EDGE_CAP, rdata);
    check("edge_cap_before_s1", rdata, 32'h0);
    check("irq_low_at_s1", {31'd0, irq}, 32'd0);
    rd(ADDR_EDGE_CAP, rdata);
    check("edge_cap_rise", rdata, 32'h1);
    check("irq_high_at_s2", {31'd0, irq}, 32'd1);
    wr(ADDR_EDGE_CAP, 32'h1, 4'hF);
    check("irq_held_after_w1c", {31'd0, irq}, 32'd1);
    tick(1);
    check("irq_clear_after_w1c", {31'd0, irq}, 32'd0);
    rd(ADDR_EDGE_CAP, rdata);
    check("edge_cap_cleared", rdata, 32'h0);

    tb_val[0] = 1'b0;
    tick(5);
    rd(ADDR_EDGE_CAP, rdata);
    check("fall_disabled", rdata, 32'h0);
    check("irq_fall_disabled", {31'd0, irq}, 32'd0);

    // Edge on pin3 lands on the same clock as its W1C.
    wr(ADDR_RISE_EN, 32'h9, 4'hF);
    tb_val[3] = 1'b1;
    tick(2);
    wr(ADDR_EDGE_CAP, 32'h8, 4'hF);
    rd(ADDR_EDGE_CAP, rdata);
    check("edge_w1c_collision", rdata, 32'h8);
    check("irq_masked_bit3", {31'd0, irq}, 32'd0);
    wr(ADDR_EDGE_CAP, 32'h8, 4'h2);
    rd(ADDR_EDGE_CAP, rdata);
    check("w1c_lane_disabled", rdata, 32'h8);
    wr(ADDR_EDGE_CAP, 32'h8, 4'h1);
    rd(ADDR_EDGE_CAP, rdata);
    check("w1c_lane_enabled", rdata, 32'h0);

    // Read and write together: write wins, readdata is 0.
    bus.avs_address = ADDR_RISE_EN;
    bus.avs_writedata = 32'h5;
    bus.avs_byteenable = 4'hF;
    bus.avs_write = 1'b1;
    bus.avs_read = 1'b1;
    tick(1);
    bus.avs_write = 1'b0;
    bus.avs_read = 1'b0;
    check("rw_collision_rdata", bus.avs_readdata, 32'h0);
    rd(ADDR_RISE_EN, rdata);
    check("rw_collision_write", rdata, 32'h5);

    // WIDTH=8 instance: upper bits neither stored nor read.
    bus8.avs_address = ADDR_DIR;
    bus8.avs_writedata = 32'hFFFF_FFFF;
    bus8.avs_byteenable = 4'hF;
    bus8.avs_write = 1'b1;
    tick(1);
    bus8.avs_write = 1'b0;
    check("w8_rdata_before_read", bus8.avs_readdata, 32'h0);
    bus8.avs_read = 1'b1;
    tick(1);
    bus8.avs_read = 1'b0;
    check("w8_dir_read", bus8.avs_readdata, 32'h0000_00FF);
    tick(1);
    check("w8_rdata_after", bus8.avs_readdata, 32'h0);

    // Asynchronous reset during an in-flight read.
    bus.avs_address = ADDR_RISE_EN;
    bus.avs_read = 1'b1;
    #3 rst_n = 1'b0;
    @(posedge clk);
    #1;
    bus.avs_read = 1'b0;
    check("reset_inflight_rdata", bus.avs_readdata, 32'h0);
    #2 rst_n = 1'b1;
    tick(1);
    rd(ADDR_RISE_EN, rdata);
    check("reset_rise_en", rdata, 32'h0);
    check("reset_irq_end", {31'd0, irq}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
